mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
- Iterative 32-bit multiply/divide unit in the EX stage, placed beside the combinational ALU.
- Takes the same ID/EX operands (src1/src2) and produces a 64-bit HI/LO result over multiple cycles.
- Replaces the single-cycle multiply path of the ALU for MULT/MULTU/DIV/DIVU.
- busy_o drives the hazard unit, which stalls the front end while an operation is running.

Parameters:
- WIDTH, 32: operand width. HI and LO are each WIDTH bits.
- CNT_W, 6: iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk_i  input  1  clock. All logic acts on the rising edge.
- rst_i  input  1  synchronous reset, active-high.
- start_i  input  1  request a new operation. Accepted only in IDLE.
- op_i  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV. Sampled on accept.
- src1_i  input  WIDTH  multiplicand / dividend. Sampled on accept.
- src2_i  input  WIDTH  multiplier / divisor. Sampled on accept.
- busy_o  output  1  high while state is RUN or DONE.
- done_o  output  1  one-cycle pulse when hi_o/lo_o become valid.
- div_zero_o  output  1  divisor was zero. Valid with done_o; held until the next accept.
- hi_o  output  WIDTH  mult: upper product. div: remainder.
- lo_o  output  WIDTH  mult: lower product. div: quotient.

Behaviour:
- Reset (rst_i=1 at an edge):
  - state goes to IDLE.
  - busy_o, done_o, div_zero_o, hi_o, lo_o, counter and internal registers all go to 0.
  - rst_i overrides start_i.
  - Reset mid-operation aborts the operation; no done_o pulse is produced.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN when start_i=1.
  - RUN -> DONE when the counter reaches WIDTH-1 at an edge.
  - DONE -> IDLE unconditionally.
- Accept (edge N, IDLE, start_i=1):
  - Latch op_i.
  - Latch operand magnitudes: two's-complement absolute value for signed ops, raw value for unsigned ops.
  - Latch the result sign flags.
  - Clear the accumulator; counter = 0.
- Timing:
  - RUN occupies edges N+1 .. N+WIDTH, one iteration per edge (32 iterations at the default width).
  - State is DONE during the cycle after edge N+WIDTH. In that cycle done_o=1 and hi_o/lo_o hold the final results.
  - Latency is WIDTH+1 cycles from accept to the done_o cycle. Throughput is one operation per WIDTH+2 cycles.
- start_i is ignored in RUN and DONE; there is no queueing.
  - start_i=1 in the DONE cycle is dropped.
  - A new op is accepted only on an edge where the state is IDLE.
- hi_o and lo_o:
  - Updated only when entering DONE, so intermediate iterations are never visible.
  - Held stable in IDLE until the next result.
- Multiply:
  - Radix-2 shift-add on unsigned magnitudes, giving a 2*WIDTH-bit product.
  - MULT negates the 64-bit product if the operand signs differ.
- Divide:
  - Radix-2 restoring division on magnitudes.
  - DIV: quotient is negated if the operand signs differ; remainder takes the sign of the dividend (truncating division).
- Boundary conditions:
  - Divisor = 0: same latency; lo_o = all ones, hi_o = src1_i as latched, div_zero_o=1.
  - DIV 0x80000000 / 0xFFFFFFFF: lo_o=0x80000000, hi_o=0, div_zero_o=0.
  - MULT 0x80000000 * 0x80000000: {hi_o,lo_o} = 0x4000000000000000.
  - Operands of 0: normal latency, result 0.
- div_zero_o is cleared on accept and set in the DONE cycle; it is never set for multiply ops.

Test Plan:
- Reset mid-RUN: start MULTU 5*7, assert rst_i at cycle 10 -> next cycle busy_o=0, hi_o=lo_o=0; no done_o within 40 cycles.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> done_o exactly 33 cycles after accept; hi_o=0xFFFFFFFE, lo_o=0x00000001; busy_o high for 33 cycles.
- MULT -3*7 -> hi_o=0xFFFFFFFF, lo_o=0xFFFFFFEB.
- DIV -7/2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF. DIVU 100/7 -> lo_o=14, hi_o=2.
- DIVU 0x1234/0 -> lo_o=0xFFFFFFFF, hi_o=0x1234, div_zero_o=1 with done_o. A following MULTU 2*3 -> div_zero_o=0, lo_o=6.
- Back-to-back: start_i held high continuously -> second op accepted on the edge after the DONE cycle; second done_o 34 cycles after the first; start_i during RUN has no effect on the results.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide for the EX stage: MULTU/MULT (shift-add) and DIVU/DIV (restoring), HI/LO result.
// Latency WIDTH+1 cycles from accept to the done_o cycle; throughput one op per WIDTH+2 cycles.
// Backpressure: start_i is honoured only in IDLE (no queueing); busy_o stalls the front end while RUN/DONE.
// Ports: clk_i/rst_i (sync, active-high) | start_i, op_i[1:0] (00 MULTU, 01 MULT, 10 DIVU, 11 DIV), src1_i, src2_i
//        busy_o, done_o (1-cycle pulse), div_zero_o (held until next accept), hi_o (upper/remainder), lo_o (lower/quotient)
module mul_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_zero_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e               state_q, state_d;
    logic [1:0]           op_q, op_d;          // bit1: divide, bit0: signed
    logic [WIDTH-1:0]     a_q, a_d;            // multiplicand / dividend magnitude (shifted left on divide)
    logic [WIDTH-1:0]     b_q, b_d;            // multiplier magnitude (shifted right on multiply) / divisor
    logic [WIDTH-1:0]     src1_q, src1_d;      // raw dividend, returned as HI on divide-by-zero
    logic [2*WIDTH-1:0]   acc_q, acc_d;        // {upper, lower} accumulator or {remainder, quotient}
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 neg_q, neg_d;        // negate product / quotient
    logic                 rem_neg_q, rem_neg_d;// negate remainder (dividend was negative)
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 div_zero_q, div_zero_d;

    // Operand signs, only meaningful for the signed ops.
    logic src1_neg, src2_neg;
    assign src1_neg = op_i[0] & src1_i[WIDTH-1];
    assign src2_neg = op_i[0] & src2_i[WIDTH-1];

    // One shift-add multiply step: add the multiplicand into the upper half when the
    // current multiplier bit is set, then shift the whole accumulator right by one.
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_acc;
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (b_q[0] ? {1'b0, a_q} : '0);
    assign mul_acc = {mul_sum, acc_q[WIDTH-1:1]};

    // One restoring divide step: shift the next dividend bit into the partial remainder
    // and subtract the divisor if it fits; the fit flag is the new quotient bit.
    logic [WIDTH:0]       div_trial;
    logic [WIDTH:0]       div_diff;
    logic                 div_ge;
    logic [WIDTH-1:0]     div_rem;
    logic [2*WIDTH-1:0]   div_acc;
    assign div_trial = {acc_q[2*WIDTH-1:WIDTH], a_q[WIDTH-1]};
    assign div_diff  = div_trial - {1'b0, b_q};
    assign div_ge    = (div_trial >= {1'b0, b_q});
    assign div_rem   = div_ge ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0];
    assign div_acc   = {div_rem, acc_q[WIDTH-2:0], div_ge};

    // Sign-corrected final values, used only on the last iteration.
    logic [2*WIDTH-1:0]   iter_acc;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix;
    logic [WIDTH-1:0]     rem_fix;
    assign iter_acc = op_q[1] ? div_acc : mul_acc;
    assign prod_fix = neg_q ? -iter_acc : iter_acc;
    assign quo_fix  = neg_q ? -iter_acc[WIDTH-1:0] : iter_acc[WIDTH-1:0];
    assign rem_fix  = rem_neg_q ? -iter_acc[2*WIDTH-1:WIDTH] : iter_acc[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        src1_d     = src1_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        neg_d      = neg_q;
        rem_neg_d  = rem_neg_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        div_zero_d = div_zero_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d    = S_RUN;
                    op_d       = op_i;
                    a_d        = src1_neg ? -src1_i : src1_i;
                    b_d        = src2_neg ? -src2_i : src2_i;
                    src1_d     = src1_i;
                    acc_d      = '0;
                    cnt_d      = '0;
                    neg_d      = src1_neg ^ src2_neg;
                    rem_neg_d  = src1_neg;
                    div_zero_d = 1'b0;
                end
            end
            S_RUN: begin
                acc_d = iter_acc;
                cnt_d = cnt_q + 1'b1;
                if (op_q[1]) begin
                    a_d = a_q << 1;
                end else begin
                    b_d = b_q >> 1;
                end
                if (cnt_q == LAST_CNT) begin
                    state_d = S_DONE;
                    if (!op_q[1]) begin
                        {hi_d, lo_d} = prod_fix;
                    end else if (b_q == '0) begin
                        // Divide-by-zero: all-ones quotient, dividend passed through as remainder.
                        hi_d       = src1_q;
                        lo_d       = '1;
                        div_zero_d = 1'b1;
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            src1_q     <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            neg_q      <= 1'b0;
            rem_neg_q  <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            src1_q     <= src1_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            neg_q      <= neg_d;
            rem_neg_q  <= rem_neg_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign busy_o     = (state_q != S_IDLE);
    assign done_o     = (state_q == S_DONE);
    assign div_zero_o = div_zero_q;
    assign hi_o       = hi_q;
    assign lo_o       = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed boundary cases plus randomized ops vs. an arithmetic reference.
// Inputs driven and outputs sampled on the falling edge of clk.
// Reports one summary line; every mismatch prints a FAIL line.
module tb_mul_div_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] s1;
    logic [31:0] s2;
    logic        busy;
    logic        done;
    logic        dz;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mul_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .op_i       (op),
        .src1_i     (s1),
        .src2_i     (s2),
        .busy_o     (busy),
        .done_o     (done),
        .div_zero_o (dz),
        .hi_o       (hi),
        .lo_o       (lo)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference result {div_zero, hi, lo} from plain integer arithmetic.
    function automatic logic [64:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, p;
        logic [64:0]     res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        res = '0;
        case (o)
            2'b00: begin p = ua * ub; res = {1'b0, p}; end
            2'b01: begin q = sa * sb; res = {1'b0, q}; end
            2'b10: begin
                if (b == 32'd0) res = {1'b1, a, 32'hFFFF_FFFF};
                else res = {1'b0, a % b, a / b};
            end
            default: begin
                if (b == 32'd0) res = {1'b1, a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {1'b0, r[31:0], q[31:0]};
                end
            end
        endcase
        return res;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    // Issue one op from IDLE, scribble on the inputs after accept, wait for done_o and check everything.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [64:0] e;
        int cyc;
        int nbusy;
        e = ref_model(o, a, b);
        @(negedge clk);
        start = 1'b1; op = o; s1 = a; s2 = b;
        @(negedge clk);
        start = 1'b0; op = 2'($urandom); s1 = $urandom; s2 = $urandom;
        cyc = 1;
        nbusy = busy ? 1 : 0;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (busy) nbusy++;
        end
        check_val({tag, "_latency"}, 64'(cyc), 64'd33);
        check_val({tag, "_busy_cycles"}, 64'(nbusy), 64'd33);
        check_val({tag, "_hi"}, 64'(hi), 64'(e[63:32]));
        check_val({tag, "_lo"}, 64'(lo), 64'(e[31:0]));
        check_val({tag, "_div_zero"}, 64'(dz), 64'(e[64]));
    endtask

    initial begin
        logic [64:0] e1, e2;
        int cyc;
        logic seen_done;

        rst = 1'b1; start = 1'b0; op = 2'b00; s1 = '0; s2 = '0;
        repeat (2) @(negedge clk);
        check_val("reset_busy", 64'(busy), 64'd0);
        check_val("reset_done", 64'(done), 64'd0);
        check_val("reset_dz", 64'(dz), 64'd0);
        check_val("reset_hi", 64'(hi), 64'd0);
        check_val("reset_lo", 64'(lo), 64'd0);
        rst = 1'b0;

        // Directed cases.
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        check_val("multu_max_hi_exp", 64'(hi), 64'h0000_0000_FFFF_FFFE);
        run_op(2'b01, 32'hFFFF_FFFD, 32'd7, "mult_neg3x7");
        check_val("mult_neg3x7_lo_exp", 64'(lo), 64'h0000_0000_FFFF_FFEB);
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, "div_neg7by2");
        run_op(2'b10, 32'd100, 32'd7, "divu_100by7");
        check_val("divu_100by7_lo_exp", 64'(lo), 64'd14);
        run_op(2'b10, 32'h0000_1234, 32'd0, "divu_by0");
        check_val("divu_by0_hi_exp", 64'(hi), 64'h1234);
        run_op(2'b00, 32'd2, 32'd3, "multu_after_dz");
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        run_op(2'b01, 32'h8000_0000, 32'h8000_0000, "mult_min_sq");
        run_op(2'b11, 32'hFFFF_FFF9, 32'd0, "div_neg_by0");
        run_op(2'b01, 32'd0, 32'hFFFF_FFFF, "mult_zero");
        run_op(2'b11, 32'd0, 32'd5, "div_zero_dividend");

        // Result must be held stable in IDLE.
        @(negedge clk);
        check_val("hold_busy", 64'(busy), 64'd0);
        check_val("hold_lo", 64'(lo), 64'd0);

        // Back-to-back with start held high: RUN/DONE starts are dropped.
        e1 = ref_model(2'b01, 32'hFFFF_FFFD, 32'd7);
        e2 = ref_model(2'b10, 32'd100, 32'd7);
        @(negedge clk);
        start = 1'b1; op = 2'b01; s1 = 32'hFFFF_FFFD; s2 = 32'd7;
        @(negedge clk);
        op = 2'b10; s1 = 32'd100; s2 = 32'd7;
        cyc = 1;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check_val("b2b_first_latency", 64'(cyc), 64'd33);
        check_val("b2b_first_hi", 64'(hi), 64'(e1[63:32]));
        check_val("b2b_first_lo", 64'(lo), 64'(e1[31:0]));
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done && cyc < 100);
        start = 1'b0;
        check_val("b2b_gap", 64'(cyc), 64'd34);
        check_val("b2b_second_hi", 64'(hi), 64'(e2[63:32]));
        check_val("b2b_second_lo", 64'(lo), 64'(e2[31:0]));
        check_val("b2b_second_dz", 64'(dz), 64'(e2[64]));

        // Reset in the middle of RUN aborts the op.
        @(negedge clk);
        start = 1'b1; op = 2'b00; s1 = 32'd5; s2 = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("midrst_busy", 64'(busy), 64'd0);
        check_val("midrst_hi", 64'(hi), 64'd0);
        check_val("midrst_lo", 64'(lo), 64'd0);
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        check_val("midrst_no_done", 64'(seen_done), 64'd0);

        // Randomized ops.
        for (int i = 0; i < 24; i++) begin
            run_op(2'($urandom_range(0, 3)), pick_operand(), pick_operand(), $sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
